ysyx_23060191_ifu_fetch: RTL and testbench
==========================================

// Module: ysyx_23060191_ifu_fetch
// PURPOSE
//  Instruction-fetch controller: owns the PC and drives the instruction-memory read port (pc/rd_en),
//  then captures the returned instruction. Presents {pc, inst} to the decode stage with a valid/ready
//  handshake. Accepts PC redirects (branch/jump/trap) from the execute stage and flushes the fetch.
// PARAMETERS
//  CPU_WIDTH  32            data/address width
//  RESET_PC   32'h8000_0000 PC loaded on reset
//  MEM_LAT    1             cycles mem_rd_en is held before mem_inst is sampled; legal 1..15
// PORTS
//  clk             in   1          clock, rising edge
//  rst_n           in   1          asynchronous reset, active low
//  mem_pc          out  CPU_WIDTH  fetch address to instruction memory
//  mem_rd_en       out  1          instruction memory read enable
//  mem_inst        in   CPU_WIDTH  instruction returned by memory (combinational from mem_pc)
//  redirect_valid  in   1          redirect request from execute stage
//  redirect_pc     in   CPU_WIDTH  redirect target
//  out_valid       out  1          fetched instruction valid to decode
//  out_pc          out  CPU_WIDTH  PC of fetched instruction
//  out_inst        out  CPU_WIDTH  fetched instruction
//  out_ready       in   1          decode accepts instruction
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, cnt=0, out_valid=0, out_pc=0, out_inst=0.
//  mem_pc = pc register; mem_rd_en = (state==REQ). Both derived from registers only.
//  FSM:
//   IDLE: entered only from reset; next cycle -> REQ, cnt=0.
//   REQ:  mem_rd_en=1; cnt increments each cycle. When cnt==MEM_LAT-1: out_inst<=mem_inst,
//         out_pc<=pc, out_valid<=1, pc<=pc+4, cnt<=0 -> HOLD.
//   HOLD: mem_rd_en=0; out_* held stable. If out_ready: out_valid<=0 -> REQ (cnt=0).
//  Throughput: one instruction per MEM_LAT+1 cycles with out_ready=1; first out_valid rises
//   MEM_LAT+1 cycles after the first clk edge with rst_n=1.
//  Redirect (highest priority, any state except reset): pc<=redirect_pc with bits[1:0] forced 0,
//   cnt<=0, out_valid<=0, state<=REQ. A capture scheduled in the same cycle is discarded.
//   Redirect in HOLD with out_ready=1: handshake counts as completed, then redirect applies.
//   Redirect in IDLE: honoured identically (-> REQ at redirect target).
//  PC arithmetic modulo 2^CPU_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
//  out_valid never drops without out_ready or redirect; out_pc/out_inst unchanged while
//   out_valid=1 and out_ready=0.
//  Reset asserted mid-operation: all state returns to reset values immediately (async), in-flight
//   fetch discarded; after release restarts from IDLE at RESET_PC.
// TESTING
//  1 Reset release, MEM_LAT=1, out_ready=1 -> cyc0 IDLE; cyc1 mem_rd_en=1 mem_pc=0x80000000;
//    cyc2 out_valid=1 out_pc=0x80000000 out_inst=mem[0x80000000]; cyc4 out_pc=0x80000004.
//  2 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid=1, out_pc/out_inst constant,
//    mem_rd_en=0; raise out_ready -> next cycle REQ at pc+4.
//  3 Redirect_pc=0x80000102 in HOLD -> next cycle out_valid=0, mem_rd_en=1, mem_pc=0x80000100;
//    then out_pc=0x80000100.
//  4 Redirect on the capture cycle of REQ -> no out_valid for old PC; fetch restarts at target.
//  5 MEM_LAT=3 -> mem_rd_en high exactly 3 cycles per fetch, mem_inst sampled on 3rd; 4-cycle period.
//  6 Redirect to 0xFFFFFFFC, out_ready=1 -> outputs 0xFFFFFFFC then out_pc=0x00000000; assert rst_n=0
//    in HOLD -> out_valid=0 same cycle, mem_pc=0x80000000.

Source files
------------

// File: rtl/ysyx_23060191_ifu_fetch.sv
// ============================================================================
// Module   : ysyx_23060191_ifu_fetch
// Brief    : Instruction-fetch controller with PC, memory read port and
//            valid/ready output to decode; accepts execute-stage redirects.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_23060191_ifu_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
    parameter int                   MEM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [CPU_WIDTH-1:0] mem_pc,
    output logic                 mem_rd_en,
    input  logic [CPU_WIDTH-1:0] mem_inst,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 out_valid,
    output logic [CPU_WIDTH-1:0] out_pc,
    output logic [CPU_WIDTH-1:0] out_inst,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t               state, state_nxt;
    logic [CPU_WIDTH-1:0] pc, pc_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic                 valid_nxt;
    logic [CPU_WIDTH-1:0] opc_nxt, oinst_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            cnt       <= 4'd0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            cnt       <= cnt_nxt;
            out_valid <= valid_nxt;
            out_pc    <= opc_nxt;
            out_inst  <= oinst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        valid_nxt = out_valid;
        opc_nxt   = out_pc;
        oinst_nxt = out_inst;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                cnt_nxt   = 4'd0;
            end
            S_REQ: begin
                if (cnt == LAST_CNT) begin
                    oinst_nxt = mem_inst;
                    opc_nxt   = pc;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc + CPU_WIDTH'(4);
                    cnt_nxt   = 4'd0;
                    state_nxt = S_HOLD;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    cnt_nxt   = 4'd0;
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase

        // Redirect wins over everything, including a capture landing this cycle.
        if (redirect_valid) begin
            pc_nxt    = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
            cnt_nxt   = 4'd0;
            valid_nxt = 1'b0;
            opc_nxt   = out_pc;
            oinst_nxt = out_inst;
            state_nxt = S_REQ;
        end
    end

    assign mem_pc    = pc;
    assign mem_rd_en = (state == S_REQ);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060191_ifu_fetch.sv
// ============================================================================
// Module   : tb_ysyx_23060191_ifu_fetch
// Brief    : Random-stimulus bench for two fetch units (MEM_LAT 1 and 3)
//            against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060191_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          NCYC   = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] mem_pc    [2];
    logic        mem_rd_en [2];
    logic [31:0] mem_inst  [2];
    logic        out_valid [2];
    logic [31:0] out_pc    [2];
    logic [31:0] out_inst  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a fetch is "in flight" whenever it has started and no output is held.
    int          lat     [2] = '{1, 3};
    bit          started [2];
    int          left    [2];
    bit          m_valid [2];
    logic [31:0] m_pc    [2];
    logic [31:0] m_opc   [2];
    logic [31:0] m_oinst [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign mem_inst[0] = memf(mem_pc[0]);
    assign mem_inst[1] = memf(mem_pc[1]);

    ysyx_23060191_ifu_fetch #(.CPU_WIDTH(32), .RESET_PC(RST_PC), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .mem_pc(mem_pc[0]), .mem_rd_en(mem_rd_en[0]), .mem_inst(mem_inst[0]),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid[0]), .out_pc(out_pc[0]), .out_inst(out_inst[0]),
        .out_ready(out_ready)
    );

    ysyx_23060191_ifu_fetch #(.CPU_WIDTH(32), .RESET_PC(RST_PC), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .mem_pc(mem_pc[1]), .mem_rd_en(mem_rd_en[1]), .mem_inst(mem_inst[1]),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid[1]), .out_pc(out_pc[1]), .out_inst(out_inst[1]),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            started[i] = 1'b0;
            left[i]    = 0;
            m_valid[i] = 1'b0;
            m_pc[i]    = RST_PC;
            m_opc[i]   = '0;
            m_oinst[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (redirect_valid) begin
                started[i] = 1'b1;
                m_pc[i]    = redirect_pc & 32'hFFFF_FFFC;
                m_valid[i] = 1'b0;
                left[i]    = lat[i];
            end else if (!started[i]) begin
                started[i] = 1'b1;
                left[i]    = lat[i];
            end else if (!m_valid[i]) begin
                left[i] = left[i] - 1;
                if (left[i] == 0) begin
                    m_valid[i] = 1'b1;
                    m_opc[i]   = m_pc[i];
                    m_oinst[i] = memf(m_pc[i]);
                    m_pc[i]    = m_pc[i] + 32'd4;
                end
            end else if (out_ready) begin
                m_valid[i] = 1'b0;
                left[i]    = lat[i];
            end
        end
    endtask

    task automatic compare_all(input string when);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s[L%0d] mem_pc", when, lat[i]), mem_pc[i], m_pc[i]);
            check($sformatf("%s[L%0d] mem_rd_en", when, lat[i]), 32'(mem_rd_en[i]),
                  32'(started[i] && !m_valid[i]));
            check($sformatf("%s[L%0d] out_valid", when, lat[i]), 32'(out_valid[i]), 32'(m_valid[i]));
            check($sformatf("%s[L%0d] out_pc", when, lat[i]), out_pc[i], m_opc[i]);
            check($sformatf("%s[L%0d] out_inst", when, lat[i]), out_inst[i], m_oinst[i]);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            if (rst_n) model_step();
            @(negedge clk);
            compare_all("run");

            redirect_valid = 1'b0;
            out_ready      = ($urandom_range(0, 3) != 0);
            if (c > 6 && $urandom_range(0, 9) == 0) begin
                redirect_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0:       redirect_pc = 32'hFFFF_FFFC;
                    1:       redirect_pc = 32'h8000_0102;
                    2:       redirect_pc = $urandom;
                    default: redirect_pc = RST_PC + 32'($urandom_range(0, 1023));
                endcase
            end

            if (!rst_n) begin
                rst_n = 1'b1;
            end else if (c > 10 && $urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                compare_all("async_rst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
